// File: rtl/pwm_output_stage.sv
// Drives 16 pins from the SPI control registers. Each pin is either static or modulated
// by one shared 8-bit PWM. Duty and mode are shadowed at period boundaries so no runt pulses occur.
module pwm_output_stage #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] en_out,
  input  logic [15:0] en_pwm_mode,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_sh;
  logic [15:0] mode_sh;
  logic        tick;
  logic        boundary;
  logic        pwm_level;

  assign tick     = (pre_cnt == DIV_LAST);
  assign boundary = tick && (pwm_cnt == 8'hFF);

  // Full-scale duty must hold the pin high for the whole period, including the count of 255.
  assign pwm_level = (duty_sh == 8'hFF) ? 1'b1 : (pwm_cnt < duty_sh);

  // NOTE: every register, shadows included, is cleared by the async reset so the first
  // period after reset behaves deterministically (PWM pins static until the first boundary).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      duty_sh      <= '0;
      mode_sh      <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every term below sees the pre-edge values;
      // out therefore reflects the old period in the boundary cycle.
      pre_cnt      <= tick ? 8'd0 : pre_cnt + 8'd1;
      period_start <= boundary;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      if (boundary) begin
        duty_sh <= pwm_duty_cycle;
        mode_sh <= en_pwm_mode;
      end
      // en_out is deliberately not shadowed: enabling or disabling a pin acts next clk.
      out <= en_out & (~mode_sh | {16{pwm_level}});
    end
  end

endmodule
